// File: rtl/idx_seq_pkg.sv
// rtl/idx_seq_pkg.sv - shared state encoding and default sizing for the index sequencer
package idx_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W       = 10;
    localparam int DEF_MODULUS = 701;
    localparam int DEF_PASS_W  = 4;
    localparam int MAX_IDX     = DEF_MODULUS - 1;

endpackage

// File: rtl/idx_seq_counter_inc_prefix.sv
// rtl/idx_seq_counter_inc_prefix.sv - W-bit Sklansky AND-prefix incrementer
module inc_prefix #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] out,
    output logic         cout
);

    // A W=1 instance still needs one pass-through level so the chain below is never empty.
    localparam int LEVELS = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0] w_all_ones;

    // Each level doubles the span of the running AND; bit i ends up holding &a[i:0].
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        logic [W-1:0] w_prev;
        logic [W-1:0] w_nxt;

        if (l == 0) begin : g_first
            assign w_prev = a;
        end else begin : g_chain
            assign w_prev = g_lvl[l-1].w_nxt;
        end

        for (genvar i = 0; i < W; i++) begin : g_bit
            if (((i >> l) & 1) == 1) begin : g_comb
                assign w_nxt[i] = w_prev[i] & w_prev[((i >> l) << l) - 1];
            end else begin : g_pass
                assign w_nxt[i] = w_prev[i];
            end
        end
    end

    assign w_all_ones = g_lvl[LEVELS-1].w_nxt;

    // Bit i toggles exactly when every lower bit is one.
    assign out[0] = ~a[0];
    for (genvar i = 1; i < W; i++) begin : g_sum
        assign out[i] = a[i] ^ w_all_ones[i-1];
    end

    assign cout = w_all_ones[W-1];

endmodule

// File: rtl/idx_seq_counter.sv
// rtl/idx_seq_counter.sv - handshaked multi-pass modular coefficient-index sequencer
module idx_seq_counter
    import idx_seq_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int MODULUS = DEF_MODULUS,
    parameter int PASS_W  = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [W-1:0]      base_i,
    input  logic [PASS_W-1:0] passes_i,
    input  logic              abort_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [W-1:0]      idx_o,
    output logic [PASS_W-1:0] pass_o,
    output logic              last_o,
    output logic              final_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // MODULUS may equal 2**W, so the range check is done one bit wider.
    localparam logic [W:0]   MOD_EXT  = (W+1)'(MODULUS);
    localparam logic [W-1:0] LAST_IDX = W'(MODULUS - 1);

    state_t            r_state;
    logic [W-1:0]      r_idx;
    logic [W-1:0]      r_elem;
    logic [W-1:0]      r_base;
    logic [PASS_W-1:0] r_pass;
    logic [PASS_W-1:0] r_passes;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [W-1:0]      w_idx_inc;
    logic [W-1:0]      w_elem_inc;
    logic              w_unused_idx_cout;
    logic              w_unused_elem_cout;
    logic              w_last;
    logic              w_final;

    inc_prefix #(.W(W)) u_idx_inc (
        .a    (r_idx),
        .out  (w_idx_inc),
        .cout (w_unused_idx_cout)
    );

    inc_prefix #(.W(W)) u_elem_inc (
        .a    (r_elem),
        .out  (w_elem_inc),
        .cout (w_unused_elem_cout)
    );

    // The pass boundary is tracked by the element count, not the index, because the index starts at base.
    assign w_last  = (r_elem == LAST_IDX);
    assign w_final = w_last && (r_pass == (r_passes - PASS_W'(1)));

    // Sequencer FSM: start validation, beat advance with modular wrap, pass rollover, abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_elem   <= '0;
            r_base   <= '0;
            r_pass   <= '0;
            r_passes <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        if ({1'b0, base_i} >= MOD_EXT) begin
                            r_err <= 1'b1;
                        end else if (passes_i == '0) begin
                            r_state <= DONE;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_base   <= base_i;
                            r_passes <= passes_i;
                            r_idx    <= base_i;
                            r_elem   <= '0;
                            r_pass   <= '0;
                            r_state  <= RUN;
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (ready_i) begin
                        if (w_final) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                        if (w_last) begin
                            r_elem <= '0;
                            r_idx  <= r_base;
                            r_pass <= r_pass + PASS_W'(1);
                        end else begin
                            r_elem <= w_elem_inc;
                            r_idx  <= (r_idx == LAST_IDX) ? '0 : w_idx_inc;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign valid_o = r_valid;
    assign idx_o   = r_idx;
    assign pass_o  = r_pass;
    assign last_o  = r_valid & w_last;
    assign final_o = r_valid & w_final;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign err_o   = r_err;

endmodule

// File: tb/tb_idx_seq_counter.sv
// tb/tb_idx_seq_counter.sv - scoreboard bench for idx_seq_counter and inc_prefix
module tb_idx_seq_counter;

    localparam int W       = 10;
    localparam int MODULUS = 701;
    localparam int PASS_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [W-1:0]      base_i;
    logic [PASS_W-1:0] passes_i;
    logic              abort_i;
    logic              ready_i;
    logic              valid_o;
    logic [W-1:0]      idx_o;
    logic [PASS_W-1:0] pass_o;
    logic              last_o;
    logic              final_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    logic              s_start;
    logic [3:0]        s_base;
    logic [3:0]        s_passes;
    logic              s_valid;
    logic [3:0]        s_idx;
    logic [3:0]        s_pass;
    logic              s_last;
    logic              s_final;
    logic              s_busy;
    logic              s_done;
    logic              s_err;

    logic [9:0]        ip_a;
    logic [9:0]        ip_out  [1:10];
    logic              ip_cout [1:10];

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] sb [$];

    always #5 clk = ~clk;

    idx_seq_counter #(.W(W), .MODULUS(MODULUS), .PASS_W(PASS_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .base_i   (base_i),
        .passes_i (passes_i),
        .abort_i  (abort_i),
        .ready_i  (ready_i),
        .valid_o  (valid_o),
        .idx_o    (idx_o),
        .pass_o   (pass_o),
        .last_o   (last_o),
        .final_o  (final_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    idx_seq_counter #(.W(4), .MODULUS(16), .PASS_W(4)) dut_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (s_start),
        .base_i   (s_base),
        .passes_i (s_passes),
        .abort_i  (1'b0),
        .ready_i  (1'b1),
        .valid_o  (s_valid),
        .idx_o    (s_idx),
        .pass_o   (s_pass),
        .last_o   (s_last),
        .final_o  (s_final),
        .busy_o   (s_busy),
        .done_o   (s_done),
        .err_o    (s_err)
    );

    for (genvar gw = 1; gw <= 10; gw++) begin : g_inc
        logic [gw-1:0] o;
        inc_prefix #(.W(gw)) u_inc (
            .a    (ip_a[gw-1:0]),
            .out  (o),
            .cout (ip_cout[gw])
        );
        assign ip_out[gw] = 10'(o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected beat word: {idx, pass, last, final}.
    task automatic push_run(input int base, input int passes);
        for (int p = 0; p < passes; p++) begin
            for (int e = 0; e < MODULUS; e++) begin
                logic [W-1:0]      ei;
                logic [PASS_W-1:0] ep;
                logic              el;
                logic              ef;
                ei = W'((base + e) % MODULUS);
                ep = PASS_W'(p);
                el = (e == MODULUS - 1);
                ef = el && (p == passes - 1);
                sb.push_back({ei, ep, el, ef});
            end
        end
    endtask

    task automatic start_run(input int base, input int passes);
        push_run(base, passes);
        base_i   = W'(base);
        passes_i = PASS_W'(passes);
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        check("start_latency_valid", valid_o, 1);
        check("start_first_idx", idx_o, base);
    endtask

    task automatic run_beats(input string tag, input int n, input bit rnd, input int budget,
                             output int cycles);
        int          got;
        logic        stalled;
        logic [15:0] held;
        logic [15:0] exp;
        got     = 0;
        stalled = 1'b0;
        held    = '0;
        cycles  = 0;
        while (got < n && cycles < budget) begin
            if (stalled)
                check({tag, "_hold"}, {idx_o, pass_o, last_o, final_o}, held);
            ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check({tag, "_sb_empty"}, 1, 0);
                end else begin
                    exp = sb.pop_front();
                    check({tag, "_beat"}, {idx_o, pass_o, last_o, final_o}, exp);
                end
                got++;
                stalled = 1'b0;
            end else begin
                stalled = valid_o;
                held    = {idx_o, pass_o, last_o, final_o};
            end
            @(negedge clk);
            cycles++;
        end
        check({tag, "_beat_count"}, got, n);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done_pulse"}, done_o, 1);
        check({tag, "_done_valid"}, valid_o, 0);
        check({tag, "_done_busy"}, busy_o, 1);
        @(negedge clk);
        check({tag, "_idle_done"}, done_o, 0);
        check({tag, "_idle_busy"}, busy_o, 0);
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        base_i   = '0;
        passes_i = '0;
        abort_i  = 1'b0;
        ready_i  = 1'b1;
        s_start  = 1'b0;
        s_base   = '0;
        s_passes = '0;
        ip_a     = '0;

        // Reset state
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_idx", idx_o, 0);
        check("rst_pass", pass_o, 0);
        check("rst_last", last_o, 0);
        check("rst_final", final_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pass from 0, ready tied high
        start_run(0, 1);
        run_beats("p1", 701, 1'b0, 800, cyc);
        check("p1_no_bubbles", cyc, 701);
        check_done("p1");

        // Two passes from 699 with a start poke mid-run that must be ignored
        start_run(699, 2);
        run_beats("p2a", 500, 1'b0, 600, cyc);
        base_i   = 10'd7;
        passes_i = 4'd1;
        start_i  = 1'b1;
        run_beats("p2b", 1, 1'b0, 5, cyc);
        start_i  = 1'b0;
        run_beats("p2c", 901, 1'b0, 1000, cyc);
        check("p2_no_bubbles", cyc, 901);
        check_done("p2");

        // Random backpressure, three passes from 5
        start_run(5, 3);
        run_beats("p3", 2103, 1'b1, 20000, cyc);
        ready_i = 1'b1;
        check_done("p3");

        // Zero passes: immediate done, no beats
        base_i   = 10'd3;
        passes_i = 4'd0;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        check("zero_valid", valid_o, 0);
        check_done("zero");

        // Out-of-range base is rejected
        base_i   = 10'd701;
        passes_i = 4'd1;
        start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        check("err_pulse", err_o, 1);
        check("err_busy", busy_o, 0);
        check("err_valid", valid_o, 0);
        @(negedge clk);
        check("err_clear", err_o, 0);

        // Abort in IDLE blocks a simultaneous start
        base_i   = 10'd1;
        start_i  = 1'b1;
        abort_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        abort_i  = 1'b0;
        check("idle_abort_busy", busy_o, 0);
        check("idle_abort_valid", valid_o, 0);

        // Abort at beat 300 together with ready
        start_run(10, 1);
        run_beats("ab", 300, 1'b0, 400, cyc);
        check("ab_idx_at_abort", idx_o, 310);
        ready_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("ab_valid", valid_o, 0);
        check("ab_done", done_o, 0);
        check("ab_busy", busy_o, 0);
        @(negedge clk);
        check("ab_done_later", done_o, 0);
        sb.delete();

        // Asynchronous reset mid-run, then a fresh run
        start_run(100, 2);
        run_beats("rs", 50, 1'b0, 100, cyc);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_valid", valid_o, 0);
        check("rs_idx", idx_o, 0);
        check("rs_pass", pass_o, 0);
        check("rs_busy", busy_o, 0);
        check("rs_last", last_o, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(3, 1);
        run_beats("rs2", 701, 1'b0, 800, cyc);
        check_done("rs2");

        // Small instance: MODULUS == 2**W wrap
        s_base   = 4'd15;
        s_passes = 4'd1;
        s_start  = 1'b1;
        @(negedge clk);
        s_start  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("sm_valid", s_valid, 1);
            check("sm_idx", s_idx, (15 + k) % 16);
            check("sm_pass", s_pass, 0);
            check("sm_last", s_last, (k == 15));
            check("sm_final", s_final, (k == 15));
            @(negedge clk);
        end
        check("sm_done", s_done, 1);
        check("sm_busy", s_busy, 1);
        check("sm_err", s_err, 0);
        check("sm_valid_end", s_valid, 0);

        // Exhaustive incrementer sweep for widths 1..10
        for (int a = 0; a < 1024; a++) begin
            ip_a = 10'(a);
            #1;
            for (int w = 1; w <= 10; w++) begin
                if (a < (1 << w)) begin
                    check($sformatf("inc_out_w%0d_a%0d", w, a), ip_out[w], (a + 1) % (1 << w));
                    check($sformatf("inc_cout_w%0d_a%0d", w, a), ip_cout[w], (a == (1 << w) - 1));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/idx_seq_counter.md
Name: idx_seq_counter

Overview:
- Parametrised coefficient-index sequencer for the NTRU-HRSS polynomial datapath (default n = 701).
- Emits indices base, base+1, ..., wrapping at MODULUS, for a run-time number of passes.
- Uses a valid/ready handshake toward the consuming MAC/memory stage.
- Generalises the fixed-width prefix incrementers into a W-bit parametrised prefix incrementer wrapped in a modular, handshaked, multi-pass counter.

Parameters:
- W, 10: index width in bits.
- MODULUS, 701: index range; indices run 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**W.
- PASS_W, 4: width of the pass counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- base_i  in  W  first index of each pass; must be < MODULUS.
- passes_i  in  PASS_W  number of passes; 0 is legal.
- abort_i  in  1  synchronous abort.
- ready_i  in  1  consumer accepts the current index.
- valid_o  out  1  idx_o is valid.
- idx_o  out  W  current index.
- pass_o  out  PASS_W  current pass number, 0-based.
- last_o  out  1  current beat is the last index of its pass.
- final_o  out  1  current beat is the last beat of the whole run.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse when the run completes.
- err_o  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; internal idx, element count and pass registers are 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start_i=1 with base_i >= MODULUS: stay in IDLE; err_o=1 next cycle.
  - start_i=1 with passes_i=0: go to DONE; no beats are emitted.
  - start_i=1 otherwise:
    - Capture base_i and passes_i.
    - Set idx=base_i, elem=0, pass=0.
    - Go to RUN; valid_o=1 on the cycle after the start edge (latency 1).
- RUN:
  - valid_o=1 throughout.
  - A beat completes on a cycle with valid_o & ready_i.
  - Without a completed beat, idx_o, pass_o, last_o and final_o hold stable.
  - On a completed beat:
    - idx advances to idx+1 (via the incrementer), or to 0 if idx == MODULUS-1.
    - elem advances to elem+1.
    - If elem == MODULUS-1: elem=0, idx=base, pass=pass+1.
  - last_o = (elem == MODULUS-1).
  - final_o = last_o & (pass == passes-1).
  - A completed beat with final_o=1 moves to DONE; valid_o=0 on the next cycle.
- DONE: lasts exactly one cycle with done_o=1 and busy_o=1, then returns to IDLE.
  - start_i is ignored while in DONE.
- start_i is ignored whenever busy_o=1; it is not queued.
- abort_i in RUN or DONE:
  - Go to IDLE on the next edge; valid_o=0 and done_o=0 on that cycle.
  - abort_i has priority over a simultaneous beat.
  - abort_i in IDLE has no effect and also blocks a simultaneous start.
- Wrap and width rules:
  - Compare idx against MODULUS-1 explicitly; do not rely on W-bit overflow.
  - When MODULUS == 2**W, the explicit wrap and natural overflow agree.
  - The incrementer's carry-out is unused.
- Per pass:
  - Exactly MODULUS beats, ending at (base-1) mod MODULUS.
  - Total beats in a run = passes_i * MODULUS.
- Throughput: with ready_i tied high, one beat per cycle, no bubbles between passes.

Decomposition:
- Package idx_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default W, MODULUS and PASS_W constants;
  - the localparam MAX_IDX = MODULUS-1.
- Sub-module inc_prefix #(W): purely combinational Sklansky AND-prefix incrementer.
  - Ports: a[W-1:0] in; out[W-1:0] and cout out.
  - Prefix tree built with generate loops.
  - Instantiated twice, once for idx and once for elem.
  - Verified standalone by exhaustive sweep for W ≤ 10.
- Pass count increments use the plain + operator (narrow width).

Test Plan:
- base=0, passes=1, ready_i=1:
  - 701 consecutive beats 0..700; valid_o first high 1 cycle after start.
  - last_o and final_o high only on idx 700; done_o pulses on the cycle after; busy_o low the cycle after that.
- base=699, passes=2:
  - Sequence 699, 700, 0, ..., 698, repeated.
  - pass_o 0 then 1; last_o on each 698; final_o only on the second 698.
  - No gap cycle between the passes.
- Random ready_i (50%), base=5, passes=3:
  - idx_o, pass_o and last_o stable during every ready_i=0 cycle.
  - Total accepted beats = 2103; the scoreboard matches the modular sequence.
- Edge starts:
  - passes=0 → done_o at start+1 with valid_o never high.
  - base=701 → err_o pulse, busy_o stays 0.
  - start_i during RUN → ignored, sequence undisturbed.
- Abort and reset during a run:
  - abort_i at beat 300 together with ready_i=1 → beat not counted; next cycle IDLE, valid_o=0, no done_o.
  - rst_n low mid-run (asynchronous, off-edge) → all outputs 0 immediately.
  - A new start after reset runs from the fresh base.
- W=4, MODULUS=16, base=15, passes=1:
  - Sequence 15, 0, 1, ..., 14, with natural-overflow wrap.
  - Separately, inc_prefix exhaustive check for W=1..10: out == a+1 mod 2**W, cout == &a.
